md_scheduler: RTL and testbench

Sequencer for the HI/LO multiply-divide resource in the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and models a fixed multi-cycle latency with a busy window. It owns the HI and LO registers and raises the D-stage stall request whenever an HI/LO instruction would otherwise collide with an operation in flight.

---
 rtl/md_scheduler_pkg.sv | 31 +++
 rtl/md_scheduler_arith.sv | 66 ++++++
 rtl/md_scheduler.sv | 130 +++++++++++++
 tb/tb_md_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// md_scheduler_pkg
// Shared constants for the HI/LO multiply-divide resource.
//   MD_*        : 4-bit E-stage HI/LO opcode encoding
//   md_state_e  : sequencer state encoding
//   md_abs      : 32-bit two's-complement magnitude helper
// ---------------------------------------------------------------------------
package md_scheduler_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
  // is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_scheduler_arith.sv
// ---------------------------------------------------------------------------
// md_arith
// Purely combinational multiply/divide datapath.
//   mdop        in  4   opcode (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU used)
//   rs, rt      in  32  operands (rs = multiplicand / dividend)
//   result      out 64  {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out 1   div/divu with rt == 0 (result must not be committed)
// ---------------------------------------------------------------------------
module md_arith (
  input  logic [3:0]  mdop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_by_zero
);
  import md_scheduler_pkg::*;

  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic        [31:0] divisor_s;
  logic        [31:0] dvd_mag_s;
  logic        [31:0] dvs_mag_s;
  logic        [31:0] q_mag_s;
  logic        [31:0] r_mag_s;
  logic        [31:0] sq_s;
  logic        [31:0] sr_s;
  logic        [31:0] uq_s;
  logic        [31:0] ur_s;
  logic               is_div_s;

  assign is_div_s    = (mdop == MD_DIV) | (mdop == MD_DIVU);
  assign div_by_zero = is_div_s & (rt == 32'd0);

  assign smul_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign umul_s = {32'd0, rs} * {32'd0, rt};

  // A zero divisor is replaced by 1 so the dividers never see /0; the
  // result is discarded by the scheduler anyway.
  assign divisor_s = (rt == 32'd0) ? 32'd1 : rt;

  // Signed division on magnitudes: quotient negative when signs differ,
  // remainder follows the dividend. 0x80000000 / -1 falls out as
  // 0x80000000 with remainder 0 without any special case.
  assign dvd_mag_s = md_abs(rs);
  assign dvs_mag_s = md_abs(divisor_s);
  assign q_mag_s   = dvd_mag_s / dvs_mag_s;
  assign r_mag_s   = dvd_mag_s % dvs_mag_s;
  assign sq_s      = (rs[31] ^ divisor_s[31]) ? (32'd0 - q_mag_s) : q_mag_s;
  assign sr_s      = rs[31] ? (32'd0 - r_mag_s) : r_mag_s;

  assign uq_s = rs / divisor_s;
  assign ur_s = rs % divisor_s;

  // Result select by opcode.
  always_comb begin
    result = 64'd0;
    case (mdop)
      MD_MULT:  result = smul_s;
      MD_MULTU: result = umul_s;
      MD_DIV:   result = {sr_s, sq_s};
      MD_DIVU:  result = {ur_s, uq_s};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
// Sequencer for the HI/LO multiply-divide resource. Owns HI/LO, models a
// fixed latency busy window and raises the D-stage stall request.
//   clk, reset  in  1   clock, synchronous active-high reset
//   start_E     in  1   E-stage mult/multu/div/divu
//   mdop_E      in  4   E-stage HI/LO opcode
//   rs_E, rt_E  in  32  forwarded operands
//   md_D        in  1   D-stage instruction uses HI/LO
//   busy        out 1   operation in flight
//   stall_md    out 1   stall request (combinational)
//   mf_data_E   out 32  HI/LO read for mfhi/mflo, else 0 (combinational)
//   hi, lo      out 32  architectural HI/LO
// ---------------------------------------------------------------------------
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [3:0]  mdop_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] mf_data_E,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import md_scheduler_pkg::*;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_commit_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  logic [63:0]      arith_result_s;
  logic             div_by_zero_s;
  logic             is_div_s;

  md_arith u_arith (
    .mdop        (mdop_E),
    .rs          (rs_E),
    .rt          (rt_E),
    .result      (arith_result_s),
    .div_by_zero (div_by_zero_s)
  );

  assign is_div_s = (mdop_E == MD_DIV) | (mdop_E == MD_DIVU);

  // Sequencer FSM: latch result on start, count down, commit on the last
  // busy cycle so new HI/LO appear in the same cycle busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      pend_hi_r     <= 32'd0;
      pend_lo_r     <= 32'd0;
      pend_commit_r <= 1'b0;
      hi_r          <= 32'd0;
      lo_r          <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_E) begin
            state_r       <= ST_RUN;
            pend_hi_r     <= arith_result_s[63:32];
            pend_lo_r     <= arith_result_s[31:0];
            // Divide by zero still occupies the unit but leaves HI/LO alone.
            pend_commit_r <= ~div_by_zero_s;
            cnt_r         <= is_div_s ? DIV_CNT : MULT_CNT;
          end else if (mdop_E == MD_MTHI) begin
            hi_r <= rs_E;
          end else if (mdop_E == MD_MTLO) begin
            lo_r <= rs_E;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // mthi/mtlo/start_E are ignored here; the stall keeps them out.
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            if (pend_commit_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy     = (state_r == ST_RUN);
  assign stall_md = md_D & (start_E | busy);
  assign hi       = hi_r;
  assign lo       = lo_r;

  // HI/LO read port for mfhi/mflo in E.
  always_comb begin
    mf_data_E = 32'd0;
    case (mdop_E)
      MD_MFHI: mf_data_E = hi_r;
      MD_MFLO: mf_data_E = lo_r;
      default: mf_data_E = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler
// Scoreboarded bench for md_scheduler: stimulus pushes the expected HI/LO
// and busy length of each operation; a monitor pops on every busy fall.
// ---------------------------------------------------------------------------
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start_E;
  logic [3:0]  mdop_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] mf_data_E;
  logic [31:0] hi;
  logic [31:0] lo;

  md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_E   (start_E),
    .mdop_E    (mdop_E),
    .rs_E      (rs_E),
    .rt_E      (rt_E),
    .md_D      (md_D),
    .busy      (busy),
    .stall_md  (stall_md),
    .mf_data_E (mf_data_E),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural meaning of each op with wide integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cur_hi,
                                         input logic [31:0] cur_lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = {cur_hi, cur_lo};
    case (op)
      MD_MULT:  begin sq = sa * sb; res = sq; end
      MD_MULTU: begin up = ua * ub; res = up; end
      MD_DIV:   if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      MD_DIVU:  if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      default:  res = {cur_hi, cur_lo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_operand();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue a mult/div in the current cycle and ride out its busy window;
  // returns in the cycle the result commits (a new op may start there).
  task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic d_sel);
    exp_t        e;
    logic [63:0] r;
    int          n;
    n = ((op == MD_DIV) || (op == MD_DIVU)) ? DIV_N : MULT_N;
    r = ref_md(op, a, b, m_hi, m_lo);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.n  = n;
    exp_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    start_E = 1'b1; mdop_E = op; rs_E = a; rt_E = b; md_D = d_sel;
    @(negedge clk);
    check("stall_issue", {31'd0, stall_md}, {31'd0, d_sel});
    check("mf_zero", mf_data_E, 32'd0);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) begin
        start_E = 1'b0; mdop_E = MD_NONE; rs_E = $urandom; rt_E = $urandom;
      end else if (i == 2 && n > 2) begin
        // stray mthi/mtlo during RUN must be ignored
        mdop_E = ($urandom_range(0, 1) == 1) ? MD_MTHI : MD_MTLO;
        rs_E   = $urandom;
      end else begin
        mdop_E = MD_NONE;
      end
      @(negedge clk);
      check("stall_busy", {31'd0, stall_md}, {31'd0, d_sel});
    end
    tick();
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] v);
    mdop_E = op; rs_E = v; md_D = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("stall_mt", {31'd0, stall_md}, 32'd0);
    tick();
    mdop_E = MD_NONE; md_D = 1'b0;
    if (op == MD_MTHI) m_hi = v;
    else m_lo = v;
    @(negedge clk);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_busy", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic mf_op(input logic [3:0] op);
    mdop_E = op; md_D = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("mf_data", mf_data_E, (op == MD_MFHI) ? m_hi : m_lo);
    check("stall_mf", {31'd0, stall_md}, 32'd0);
    tick();
    mdop_E = MD_NONE; md_D = 1'b0;
  endtask

  // Monitor: every busy fall is a commit point; pop and compare.
  initial begin
    int   run_len;
    bit   prev_busy;
    bit   rst_seen;
    exp_t e;
    run_len = 0; prev_busy = 1'b0; rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rst_seen = 1'b1;
      end else if (busy === 1'b1) begin
        run_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (rst_seen) begin
            check("reset_hi", hi, 32'd0);
            check("reset_lo", lo, 32'd0);
          end else begin
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
            check("busy_len", 32'(run_len), 32'(e.n));
          end
        end
        run_len  = 0;
        rst_seen = 1'b0;
      end else begin
        rst_seen = 1'b0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        d;

    reset = 1'b1; start_E = 1'b0; mdop_E = MD_NONE; rs_E = 32'd0; rt_E = 32'd0; md_D = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_md}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mf", mf_data_E, 32'd0);
    tick();
    reset = 1'b0; md_D = 1'b0;

    // Directed products and quotients with fixed expected values.
    start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    @(negedge clk);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    start_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    @(negedge clk);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    tick();
    start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    tick();
    start_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
    @(negedge clk);
    check("div0_hi", hi, 32'hFFFF_FFFF);
    check("div0_lo", lo, 32'hFFFF_FFFD);
    tick();
    start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("ovf_hi", hi, 32'd0);
    check("ovf_lo", lo, 32'h8000_0000);
    tick();

    // mflo waits in D behind a mult, then reads the new LO.
    start_op(MD_MULT, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    check("stall_drop", {31'd0, stall_md}, 32'd0);
    tick();
    md_D = 1'b0; mdop_E = MD_MFLO;
    @(negedge clk);
    check("mflo_new", mf_data_E, 32'd15);
    tick();
    mdop_E = MD_NONE;

    mt_op(MD_MTHI, 32'h1234_5678);
    mf_op(MD_MFHI);
    check("mthi_hi", hi, 32'h1234_5678);

    // Back-to-back: second op issued in the commit cycle of the first.
    start_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    start_op(MD_DIVU, 32'd100, 32'd7, 1'b1);
    md_D = 1'b0;
    tick();

    // Reset in the 3rd busy cycle of a div discards the pending result.
    exp_q.push_back('{hi: 32'd0, lo: 32'd0, n: DIV_N});
    start_E = 1'b1; mdop_E = MD_DIV; rs_E = 32'd100; rt_E = 32'd7;
    tick();
    start_E = 1'b0; mdop_E = MD_NONE;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (12) tick();
    @(negedge clk);
    check("rst_no_commit_hi", hi, 32'd0);
    check("rst_no_commit_lo", lo, 32'd0);
    tick();

    // Randomized operation mix against the reference model.
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 7);
      a   = rnd_operand();
      b   = rnd_operand();
      d   = 1'($urandom_range(0, 1));
      case (sel)
        0: start_op(MD_MULT, a, b, d);
        1: start_op(MD_MULTU, a, b, d);
        2: start_op(MD_DIV, a, b, d);
        3: start_op(MD_DIVU, a, b, d);
        4: mt_op(MD_MTHI, a);
        5: mt_op(MD_MTLO, a);
        6: mf_op(MD_MFHI);
        default: mf_op(MD_MFLO);
      endcase
      md_D = 1'b0;
      if (sel < 4 && $urandom_range(0, 1) == 1) begin
        md_D = 1'b1;
        @(negedge clk);
        check("stall_idle", {31'd0, stall_md}, 32'd0);
        tick();
        md_D = 1'b0;
      end
    end

    repeat (3) tick();
    check("pending_commits", 32'(exp_q.size()), 32'd0);
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
